// File: rtl/ex_muldiv_seq_if.sv
// EX-stage <-> M-extension sequencer handshake: request operands in, stall/done/result out.
interface ex_muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            md_start;
  logic [2:0]      md_func3;
  logic [XLEN-1:0] md_op_a;
  logic [XLEN-1:0] md_op_b;
  logic            md_flush;
  logic            md_stall;
  logic            md_busy;
  logic            md_done;
  logic [XLEN-1:0] md_result;

  modport master (
    output md_start, md_func3, md_op_a, md_op_b, md_flush,
    input  md_stall, md_busy, md_done, md_result
  );

  modport slave (
    input  md_start, md_func3, md_op_a, md_op_b, md_flush,
    output md_stall, md_busy, md_done, md_result
  );
endinterface

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide beside the EX ALU: 32-step shift-add multiply or
// restoring divide on magnitudes, with signs applied at accept and in a FIX cycle.
module ex_muldiv_seq #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input logic              clk,
  input logic              rst_n,
  ex_muldiv_seq_if.slave   md
);
  localparam int CW = $clog2(ITER);
  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011,
                         F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state;
  logic [2:0]        f3;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   quot, rem, opnd, res_q;
  logic              neg_res, neg_rem, done_q;

  // Accept-side operand conditioning
  logic            sgn_a, sgn_b, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b, spec_res;
  always_comb begin
    sgn_a    = (md.md_func3 == F_MULH) | (md.md_func3 == F_MULHSU) |
               (md.md_func3 == F_DIV)  | (md.md_func3 == F_REM);
    sgn_b    = (md.md_func3 == F_MULH) | (md.md_func3 == F_DIV) | (md.md_func3 == F_REM);
    mag_a    = (sgn_a & md.md_op_a[XLEN-1]) ? -md.md_op_a : md.md_op_a;
    mag_b    = (sgn_b & md.md_op_b[XLEN-1]) ? -md.md_op_b : md.md_op_b;
    div_zero = md.md_func3[2] & (md.md_op_b == '0);
    div_ovf  = md.md_func3[2] & ~md.md_func3[0] &
               (md.md_op_a == {1'b1, {(XLEN-1){1'b0}}}) & (md.md_op_b == '1);
    // Overflow quotient equals the dividend itself (most negative value).
    if (md.md_func3[1]) spec_res = div_zero ? md.md_op_a : '0;
    else                spec_res = div_zero ? '1 : md.md_op_a;
  end

  // One iteration of each datapath
  logic [XLEN:0]     add_sum, shl, diff;
  logic [2*XLEN:0]   acc_ext;
  logic [2*XLEN-1:0] acc_nxt, prod_fix;
  logic [XLEN-1:0]   rem_nxt, quot_nxt, fix_res;
  always_comb begin
    add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
    acc_ext  = acc[0] ? {add_sum, acc[XLEN-1:0]} : {1'b0, acc};
    acc_nxt  = acc_ext[2*XLEN:1];
    shl      = {rem, quot[XLEN-1]};
    diff     = shl - {1'b0, opnd};
    rem_nxt  = diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0];
    quot_nxt = {quot[XLEN-2:0], ~diff[XLEN]};
    prod_fix = neg_res ? -acc : acc;
    case (f3)
      F_MUL:                    fix_res = prod_fix[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:            fix_res = neg_res ? -quot : quot;
      default:                  fix_res = neg_rem ? -rem : rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      f3      <= '0;
      count   <= '0;
      acc     <= '0;
      quot    <= '0;
      rem     <= '0;
      opnd    <= '0;
      res_q   <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      done_q  <= 1'b0;
    end else if (md.md_flush) begin
      state  <= S_IDLE;
      done_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (md.md_start) begin
            f3      <= md.md_func3;
            count   <= '0;
            neg_res <= (sgn_a & md.md_op_a[XLEN-1]) ^ (sgn_b & md.md_op_b[XLEN-1]);
            neg_rem <= sgn_a & md.md_op_a[XLEN-1];
            if (md.md_func3[2]) begin
              quot <= mag_a;
              rem  <= '0;
              opnd <= mag_b;
              acc  <= '0;
            end else begin
              acc  <= {{XLEN{1'b0}}, mag_b};
              opnd <= mag_a;
              quot <= '0;
              rem  <= '0;
            end
            if (div_zero | div_ovf) begin
              res_q  <= spec_res;
              done_q <= 1'b1;
              state  <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (f3[2]) begin
            rem  <= rem_nxt;
            quot <= quot_nxt;
          end else begin
            acc <= acc_nxt;
          end
          count <= count + 1'b1;
          if (count == CW'(ITER-1)) state <= S_FIX;
        end
        S_FIX: begin
          res_q  <= fix_res;
          done_q <= 1'b1;
          state  <= S_DONE;
        end
        default: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  // Flush kills stall and done in the same cycle; reset must also hold stall low.
  assign md.md_stall  = rst_n & ~md.md_flush &
                        (((state == S_IDLE) & md.md_start) | (state == S_CALC) | (state == S_FIX));
  assign md.md_busy   = (state != S_IDLE);
  assign md.md_done   = done_q & ~md.md_flush;
  assign md.md_result = res_q;
endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: directed RV32M cases plus randomized ops
// against an arithmetic reference model, latency, flush and async-reset checks.
module tb_ex_muldiv_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ex_muldiv_seq_if #(.XLEN(32)) md ();
  ex_muldiv_seq #(.XLEN(32), .ITER(32)) dut (.clk(clk), .rst_n(rst_n), .md(md));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_done_cyc;
  logic [31:0] last_res;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua, ub, sa, sb, p;
    int ia, ib;
    logic ovf;
    ua = {32'b0, a};             ub = {32'b0, b};
    sa = {{32{a[31]}}, a};       sb = {{32{b[31]}}, b};
    ia = a;                      ib = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Entered #1 after a posedge; leaves start high, returns #1 after the DONE->IDLE edge.
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int lat, stl, exp_lat;
    bit special;
    special = f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    exp_lat = special ? 1 : 34;
    md.md_start = 1'b1; md.md_func3 = f; md.md_op_a = a; md.md_op_b = b;
    lat = -1; stl = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (md.md_done) begin
        lat = n;
        last_done_cyc = cyc;
        chk({tag, "_stall_done"}, {31'b0, md.md_stall}, 32'd0);
        break;
      end
      if (md.md_stall) stl++;
      @(posedge clk); #1;
      if (n == 0) begin
        md.md_op_a = $urandom;
        md.md_op_b = $urandom;
      end
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_stall_cycles"}, stl, exp_lat);
    chk({tag, "_res"}, md.md_result, exp);
    last_res = exp;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int d1, dones;
    logic [2:0] f;
    logic [31:0] a, b;
    rst_n = 1'b0;
    md.md_start = 1'b0; md.md_func3 = '0; md.md_op_a = '0; md.md_op_b = '0; md.md_flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",   {31'b0, md.md_busy},  32'd0);
    chk("rst_stall",  {31'b0, md.md_stall}, 32'd0);
    chk("rst_done",   {31'b0, md.md_done},  32'd0);
    chk("rst_result", md.md_result,         32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_op("mul7x6",     3'd0, 32'd7,          32'd6,          32'h0000_002A);
    do_op("mulh_m1m1",  3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000);
    do_op("mulhu_m1m1", 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE);
    do_op("mulhsu",     3'd2, 32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF);
    do_op("div_m7_2",   3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD);
    do_op("rem_m7_2",   3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF);
    do_op("divu_100_7", 3'd5, 32'd100,        32'd7,          32'd14);
    do_op("remu_100_7", 3'd7, 32'd100,        32'd7,          32'd2);
    do_op("divu_by0",   3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF);
    do_op("rem_by0",    3'd6, 32'd5,          32'd0,          32'd5);
    do_op("div_ovf",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000);

    // Flush at iteration 10 of a divide
    md.md_start = 1'b1; md.md_func3 = 3'd4; md.md_op_a = 32'hFFFF_FF9C; md.md_op_b = 32'd3;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1 md.md_flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", {31'b0, md.md_stall}, 32'd0);
    chk("flush_done",  {31'b0, md.md_done},  32'd0);
    @(posedge clk); #1;
    md.md_flush = 1'b0; md.md_start = 1'b0;
    @(negedge clk);
    chk("flush_busy",   {31'b0, md.md_busy},  32'd0);
    chk("flush_stall2", {31'b0, md.md_stall}, 32'd0);
    chk("flush_result", md.md_result, last_res);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (md.md_done) dones++;
    end
    chk("flush_no_done", dones, 0);
    @(posedge clk); #1;

    // Back-to-back MULs, start never dropped
    do_op("b2b_mul1", 3'd0, 32'd1234, 32'd5678, 32'd7006652);
    d1 = last_done_cyc;
    do_op("b2b_mul2", 3'd0, 32'hFFFF_FFFD, 32'd9, 32'hFFFF_FFE5);
    chk("b2b_spacing", last_done_cyc - d1, 35);

    // Random ops against the reference model
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      do_op($sformatf("rnd%0d_f%0d", i, f), f, a, b, ref_md(f, a, b));
    end

    // Asynchronous reset mid-CALC
    md.md_start = 1'b1; md.md_func3 = 3'd0; md.md_op_a = 32'd99; md.md_op_b = 32'd77;
    repeat (12) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy",   {31'b0, md.md_busy},  32'd0);
    chk("arst_stall",  {31'b0, md.md_stall}, 32'd0);
    chk("arst_done",   {31'b0, md.md_done},  32'd0);
    chk("arst_result", md.md_result,         32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op("post_rst_divu", 3'd5, 32'd1000, 32'd33, 32'd30);
    md.md_start = 1'b0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
